// File: rtl/game_pkg.sv
// Shared constants, per-car output payload and helpers for the car input conditioning path.
package game_pkg;

    localparam int unsigned ACC_WIDTH    = 3;
    localparam int unsigned BTN_THROTTLE = 0;
    localparam int unsigned BTN_BRAKE    = 1;
    localparam int unsigned BTN_LEFT     = 2;
    localparam int unsigned BTN_RIGHT    = 3;

    localparam logic [1:0] OMEGA_POS  = 2'b10;
    localparam logic [1:0] OMEGA_NEG  = 2'b00;
    localparam logic [1:0] OMEGA_HOLD = 2'b01;

    typedef struct packed {
        logic [ACC_WIDTH-1:0] acc;
        logic [1:0]           omega;
        logic                 turbo_active;
    } car_ctrl_t;

    // Width of a counter that must hold 0..max_val (never narrower than 1 bit).
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val > 0) ? $clog2(max_val + 1) : 1;
    endfunction

    function automatic logic [1:0] omega_code(input logic left, input logic right);
        if (left && !right) return OMEGA_POS;
        if (right && !left) return OMEGA_NEG;
        return OMEGA_HOLD;
    endfunction

endpackage

// File: rtl/button_debounce.sv
// One raw active-low button: 2-flop synchroniser, inversion and a hold-time debounce counter.
module button_debounce
    import game_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_btn_n,
    output logic o_btn
);

    localparam int unsigned CNT_W = cnt_width(DEBOUNCE_CYCLES - 1);

    logic [1:0]       r_sync;
    logic             r_stable;
    logic [CNT_W-1:0] r_cnt;
    logic             w_level;

    assign w_level = ~r_sync[1];
    assign o_btn   = r_stable;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync   <= 2'b11;
            r_stable <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_sync <= {r_sync[0], i_btn_n};
            // Counter only runs while the level disagrees with the stable state.
            if (w_level == r_stable) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                r_stable <= ~r_stable;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/car_input_ctrl.sv
// Button conditioning for two cars: debounce, frame-stepped acceleration ramp and steering code.
// Optional turbo boost is built only when CAR_INPUT_TURBO_EN is defined.
module car_input_ctrl
    import game_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned ACC_MAX         = 7,
    parameter int unsigned RAMP_FRAMES     = 4,
    parameter int unsigned TURBO_FRAMES    = 30,
    parameter int unsigned TURBO_COOLDOWN  = 120
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_frame_tick,
    input  logic [3:0]           i_car1_btn_n,
    input  logic [3:0]           i_car2_btn_n,
    input  logic                 i_car1_turbo_n,
    input  logic                 i_car2_turbo_n,
    output logic [ACC_WIDTH-1:0] o_car1_acc,
    output logic [ACC_WIDTH-1:0] o_car2_acc,
    output logic [1:0]           o_car1_omega,
    output logic [1:0]           o_car2_omega,
    output logic                 o_car1_turbo_active,
    output logic                 o_car2_turbo_active
);

    localparam int unsigned RAMP_W = cnt_width(RAMP_FRAMES - 1);
    localparam car_ctrl_t   RST_OUT = '{acc: '0, omega: OMEGA_HOLD, turbo_active: 1'b0};

    logic [3:0] w_btn_raw_n [2];
    logic [3:0] w_btn       [2];

    assign w_btn_raw_n[0] = i_car1_btn_n;
    assign w_btn_raw_n[1] = i_car2_btn_n;

`ifdef CAR_INPUT_TURBO_EN
    localparam int unsigned TURBO_W = cnt_width(TURBO_FRAMES);
    localparam int unsigned COOL_W  = cnt_width(TURBO_COOLDOWN);

    logic [1:0] w_turbo_raw_n;
    logic [1:0] w_turbo;

    assign w_turbo_raw_n = {i_car2_turbo_n, i_car1_turbo_n};
`else
    logic w_unused_turbo;
    assign w_unused_turbo = i_car1_turbo_n ^ i_car2_turbo_n;
`endif

    for (genvar c = 0; c < 2; c++) begin : g_car
        for (genvar b = 0; b < 4; b++) begin : g_btn
            button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
                .i_clk   (i_clk),
                .i_rst_n (i_rst_n),
                .i_btn_n (w_btn_raw_n[c][b]),
                .o_btn   (w_btn[c][b])
            );
        end

        car_ctrl_t         r_out, w_out_nxt;
        logic [RAMP_W-1:0] r_ramp, w_ramp_nxt;
        logic              w_ramp_en;
`ifdef CAR_INPUT_TURBO_EN
        logic               r_tprev, w_tprev_nxt;
        logic [TURBO_W-1:0] r_tcnt, w_tcnt_nxt;
        logic [COOL_W-1:0]  r_cool, w_cool_nxt;

        button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_turbo (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .i_btn_n (w_turbo_raw_n[c]),
            .o_btn   (w_turbo[c])
        );

        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                r_tprev <= 1'b0;
                r_tcnt  <= '0;
                r_cool  <= '0;
            end else begin
                r_tprev <= w_tprev_nxt;
                r_tcnt  <= w_tcnt_nxt;
                r_cool  <= w_cool_nxt;
            end
        end
`endif

        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                r_out  <= RST_OUT;
                r_ramp <= '0;
            end else begin
                r_out  <= w_out_nxt;
                r_ramp <= w_ramp_nxt;
            end
        end

        // Everything advances only on a frame tick; between ticks state holds.
        always_comb begin
            w_out_nxt  = r_out;
            w_ramp_nxt = r_ramp;
            w_ramp_en  = 1'b0;
`ifdef CAR_INPUT_TURBO_EN
            w_tprev_nxt = r_tprev;
            w_tcnt_nxt  = r_tcnt;
            w_cool_nxt  = r_cool;
`endif
            if (i_frame_tick) begin
                w_out_nxt.omega = omega_code(w_btn[c][BTN_LEFT], w_btn[c][BTN_RIGHT]);
`ifdef CAR_INPUT_TURBO_EN
                w_tprev_nxt = w_turbo[c];
                if (r_out.turbo_active) begin
                    w_out_nxt.acc = ACC_WIDTH'(ACC_MAX);
                    w_ramp_nxt    = '0;
                    w_tcnt_nxt    = r_tcnt - TURBO_W'(1);
                    if (r_tcnt == TURBO_W'(1)) begin
                        w_out_nxt.turbo_active = 1'b0;
                        w_cool_nxt             = COOL_W'(TURBO_COOLDOWN);
                    end
                end else if (w_turbo[c] && !r_tprev && (r_cool == '0)) begin
                    w_out_nxt.turbo_active = 1'b1;
                    w_out_nxt.acc          = ACC_WIDTH'(ACC_MAX);
                    w_tcnt_nxt             = TURBO_W'(TURBO_FRAMES);
                    w_ramp_nxt             = '0;
                end else begin
                    if (r_cool != '0) w_cool_nxt = r_cool - COOL_W'(1);
                    w_ramp_en = 1'b1;
                end
`else
                w_ramp_en = 1'b1;
`endif
                if (w_ramp_en) begin
                    if (w_btn[c][BTN_BRAKE]) begin
                        w_out_nxt.acc = '0;
                        w_ramp_nxt    = '0;
                    end else if (w_btn[c][BTN_THROTTLE]) begin
                        if (r_ramp == RAMP_W'(RAMP_FRAMES - 1)) begin
                            w_ramp_nxt = '0;
                            if (r_out.acc < ACC_WIDTH'(ACC_MAX))
                                w_out_nxt.acc = r_out.acc + ACC_WIDTH'(1);
                        end else begin
                            w_ramp_nxt = r_ramp + RAMP_W'(1);
                        end
                    end else begin
                        w_ramp_nxt = '0;
                        if (r_out.acc != '0) w_out_nxt.acc = r_out.acc - ACC_WIDTH'(1);
                    end
                end
            end
        end
    end

    assign o_car1_acc          = g_car[0].r_out.acc;
    assign o_car2_acc          = g_car[1].r_out.acc;
    assign o_car1_omega        = g_car[0].r_out.omega;
    assign o_car2_omega        = g_car[1].r_out.omega;
    assign o_car1_turbo_active = g_car[0].r_out.turbo_active;
    assign o_car2_turbo_active = g_car[1].r_out.turbo_active;

endmodule

// File: tb/tb_car_input_ctrl.sv
// Self-checking bench for car_input_ctrl: a per-tick reference model fills a scoreboard queue
// that is drained and compared one cycle after each frame tick.
module tb_car_input_ctrl;

    localparam int DEB   = 4;
    localparam int AMAX  = 7;
    localparam int RF    = 2;
    localparam int TF    = 3;
    localparam int TCOOL = 2;

    typedef struct packed {
        logic [2:0] acc1;
        logic [2:0] acc2;
        logic [1:0] om1;
        logic [1:0] om2;
        logic       ta1;
        logic       ta2;
    } obs_t;

    localparam obs_t RST_V = '{3'd0, 3'd0, 2'b01, 2'b01, 1'b0, 1'b0};

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick = 1'b0;
    logic [3:0] b [2];
    logic       t [2];
    logic [3:0] car1_btn_n, car2_btn_n;
    logic       car1_turbo_n, car2_turbo_n;
    logic [2:0] car1_acc, car2_acc;
    logic [1:0] car1_om, car2_om;
    logic       car1_ta, car2_ta;

    obs_t got;
    obs_t exp_q [$];
    obs_t exp_v;
    obs_t last_exp;
    int   checks = 0;
    int   errors = 0;

    int   m_acc [2];
    int   m_ramp [2];
    logic [1:0] m_om [2];
    logic m_ta [2];
`ifdef CAR_INPUT_TURBO_EN
    int   m_tcnt [2];
    int   m_cool [2];
    logic m_tprev [2];
`endif

    always #5 clk = ~clk;

    assign car1_btn_n   = ~b[0];
    assign car2_btn_n   = ~b[1];
    assign car1_turbo_n = ~t[0];
    assign car2_turbo_n = ~t[1];
    assign got = {car1_acc, car2_acc, car1_om, car2_om, car1_ta, car2_ta};

    car_input_ctrl #(
        .DEBOUNCE_CYCLES (DEB),
        .ACC_MAX         (AMAX),
        .RAMP_FRAMES     (RF),
        .TURBO_FRAMES    (TF),
        .TURBO_COOLDOWN  (TCOOL)
    ) dut (
        .i_clk               (clk),
        .i_rst_n             (rst_n),
        .i_frame_tick        (tick),
        .i_car1_btn_n        (car1_btn_n),
        .i_car2_btn_n        (car2_btn_n),
        .i_car1_turbo_n      (car1_turbo_n),
        .i_car2_turbo_n      (car2_turbo_n),
        .o_car1_acc          (car1_acc),
        .o_car2_acc          (car2_acc),
        .o_car1_omega        (car1_om),
        .o_car2_omega        (car2_om),
        .o_car1_turbo_active (car1_ta),
        .o_car2_turbo_active (car2_ta)
    );

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            m_acc[c] = 0; m_ramp[c] = 0; m_om[c] = 2'b01; m_ta[c] = 1'b0;
`ifdef CAR_INPUT_TURBO_EN
            m_tcnt[c] = 0; m_cool[c] = 0; m_tprev[c] = 1'b0;
`endif
        end
    endtask

    // Reference behaviour of one frame tick for both cars; result goes onto the scoreboard.
    task automatic model_tick();
        obs_t e;
        for (int c = 0; c < 2; c++) begin
            bit ramp_en;
            ramp_en = 1'b0;
            if (b[c][2] && !b[c][3])      m_om[c] = 2'b10;
            else if (b[c][3] && !b[c][2]) m_om[c] = 2'b00;
            else                          m_om[c] = 2'b01;
`ifdef CAR_INPUT_TURBO_EN
            if (m_ta[c]) begin
                m_acc[c] = AMAX; m_ramp[c] = 0; m_tcnt[c] = m_tcnt[c] - 1;
                if (m_tcnt[c] == 0) begin m_ta[c] = 1'b0; m_cool[c] = TCOOL; end
            end else if (t[c] && !m_tprev[c] && m_cool[c] == 0) begin
                m_ta[c] = 1'b1; m_tcnt[c] = TF; m_acc[c] = AMAX; m_ramp[c] = 0;
            end else begin
                if (m_cool[c] > 0) m_cool[c] = m_cool[c] - 1;
                ramp_en = 1'b1;
            end
            m_tprev[c] = t[c];
`else
            ramp_en = 1'b1;
`endif
            if (ramp_en) begin
                if (b[c][1]) begin
                    m_acc[c] = 0; m_ramp[c] = 0;
                end else if (b[c][0]) begin
                    if (m_ramp[c] == RF - 1) begin
                        m_ramp[c] = 0;
                        if (m_acc[c] < AMAX) m_acc[c] = m_acc[c] + 1;
                    end else begin
                        m_ramp[c] = m_ramp[c] + 1;
                    end
                end else begin
                    m_ramp[c] = 0;
                    if (m_acc[c] > 0) m_acc[c] = m_acc[c] - 1;
                end
            end
        end
        e = '{3'(m_acc[0]), 3'(m_acc[1]), m_om[0], m_om[1], m_ta[0], m_ta[1]};
        exp_q.push_back(e);
    endtask

    // One 20-cycle frame ending in a tick; returns 1 ns after the edge that consumes the tick.
    task automatic frame();
        repeat (19) begin @(posedge clk); #1; end
        tick = 1'b1;
        model_tick();
        @(posedge clk); #1;
        tick = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        checks++;
        if (got !== RST_V) begin
            errors++; $display("FAIL reset_hold got %h want %h", got, RST_V);
        end
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 5; i++) begin
            frame();
            exp_v = exp_q.pop_front(); checks++;
            if (got !== exp_v) begin
                errors++; $display("FAIL idle[%0d] got %h want %h", i, got, exp_v);
            end
        end
    endtask

    task automatic test_throttle();
        b[0] = 4'b0001;
        for (int i = 1; i <= 20; i++) begin
            frame();
            exp_v = exp_q.pop_front(); checks++;
            if (got !== exp_v) begin
                errors++; $display("FAIL ramp_up tick%0d got %h want %h", i, got, exp_v);
            end
            if (i == 2 || i == 4 || i == 14) begin
                checks++;
                if (car1_acc !== 3'((i == 14) ? 7 : i / 2)) begin
                    errors++; $display("FAIL ramp_point tick%0d acc %0d", i, car1_acc);
                end
            end
        end
        b[0] = 4'b0000;
        for (int i = 0; i < 8; i++) begin
            frame();
            exp_v = exp_q.pop_front(); checks++;
            if (got !== exp_v) begin
                errors++; $display("FAIL ramp_down[%0d] got %h want %h", i, got, exp_v);
            end
        end
        checks++;
        if (car1_acc !== 3'd0 || car2_acc !== 3'd0) begin
            errors++; $display("FAIL ramp_end acc1 %0d acc2 %0d want 0 0", car1_acc, car2_acc);
        end
    endtask

    task automatic test_glitch_brake();
        b[0] = 4'b0001;
        repeat (3) begin @(posedge clk); #1; end
        b[0] = 4'b0000;
        for (int i = 0; i < 2; i++) begin
            frame();
            exp_v = exp_q.pop_front(); checks++;
            if (got !== exp_v) begin
                errors++; $display("FAIL glitch[%0d] got %h want %h", i, got, exp_v);
            end
        end
        b[0] = 4'b0001;
        for (int i = 0; i < 10; i++) begin
            frame();
            exp_v = exp_q.pop_front(); checks++;
            if (got !== exp_v) begin
                errors++; $display("FAIL to_acc5[%0d] got %h want %h", i, got, exp_v);
            end
        end
        b[0] = 4'b0011;
        frame();
        exp_v = exp_q.pop_front(); checks++;
        if (got !== exp_v || car1_acc !== 3'd0) begin
            errors++; $display("FAIL brake got %h want %h", got, exp_v);
        end
        b[0] = 4'b0000;
        frame();
        exp_v = exp_q.pop_front(); checks++;
        if (got !== exp_v) begin
            errors++; $display("FAIL brake_release got %h want %h", got, exp_v);
        end
    endtask

    task automatic test_steer();
        logic [3:0] pat [4];
        pat[0] = 4'b0100; pat[1] = 4'b1000; pat[2] = 4'b1100; pat[3] = 4'b0000;
        frame();
        last_exp = exp_q.pop_front();
        for (int i = 0; i < 4; i++) begin
            b[0] = pat[i];
            b[1] = pat[(i + 1) % 4];
            repeat (10) begin @(posedge clk); #1; end
            checks++;
            if (got !== last_exp) begin
                errors++; $display("FAIL steer_early[%0d] got %h want %h", i, got, last_exp);
            end
            frame();
            exp_v = exp_q.pop_front(); checks++;
            if (got !== exp_v) begin
                errors++; $display("FAIL steer[%0d] got %h want %h", i, got, exp_v);
            end
            last_exp = exp_v;
        end
    endtask

    task automatic test_async_reset();
        b[0] = 4'b0001;
        b[1] = 4'b0100;
        for (int i = 0; i < 8; i++) begin
            frame();
            exp_v = exp_q.pop_front(); checks++;
            if (got !== exp_v) begin
                errors++; $display("FAIL to_acc4[%0d] got %h want %h", i, got, exp_v);
            end
        end
        repeat (7) begin @(posedge clk); #1; end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (got !== RST_V) begin
            errors++; $display("FAIL async_reset got %h want %h", got, RST_V);
        end
        model_reset();
        b[0] = 4'b0000;
        b[1] = 4'b0000;
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            frame();
            exp_v = exp_q.pop_front(); checks++;
            if (got !== exp_v) begin
                errors++; $display("FAIL post_reset[%0d] got %h want %h", i, got, exp_v);
            end
        end
    endtask

    task automatic test_turbo();
        b[0] = 4'b0001;
        for (int i = 0; i < 4; i++) begin
            frame();
            exp_v = exp_q.pop_front(); checks++;
            if (got !== exp_v) begin
                errors++; $display("FAIL to_acc2[%0d] got %h want %h", i, got, exp_v);
            end
        end
        t[0] = 1'b1;
        frame();
        exp_v = exp_q.pop_front(); checks++;
        if (got !== exp_v) begin
            errors++; $display("FAIL turbo_press got %h want %h", got, exp_v);
        end
        checks++;
`ifdef CAR_INPUT_TURBO_EN
        if (car1_acc !== 3'd7 || car1_ta !== 1'b1) begin
            errors++; $display("FAIL turbo_on acc %0d active %b want 7 1", car1_acc, car1_ta);
        end
`else
        if (car1_acc !== 3'd2 || car1_ta !== 1'b0) begin
            errors++; $display("FAIL turbo_off acc %0d active %b want 2 0", car1_acc, car1_ta);
        end
`endif
        b[0] = 4'b0011;
        t[0] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            frame();
            exp_v = exp_q.pop_front(); checks++;
            if (got !== exp_v) begin
                errors++; $display("FAIL turbo_hold[%0d] got %h want %h", i, got, exp_v);
            end
        end
        b[0] = 4'b0000;
        t[0] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i == 2) t[0] = 1'b0;
            frame();
            exp_v = exp_q.pop_front(); checks++;
            if (got !== exp_v || car1_ta !== 1'b0) begin
                errors++; $display("FAIL cooldown[%0d] got %h want %h", i, got, exp_v);
            end
        end
        for (int i = 0; i < 8; i++) begin
            frame();
            exp_v = exp_q.pop_front(); checks++;
            if (got !== exp_v) begin
                errors++; $display("FAIL turbo_decay[%0d] got %h want %h", i, got, exp_v);
            end
        end
    endtask

    initial begin
        b[0] = 4'b0000; b[1] = 4'b0000;
        t[0] = 1'b0;    t[1] = 1'b0;
        model_reset();
        test_reset();
        test_throttle();
        test_glitch_brake();
        test_steer();
        test_async_reset();
        test_turbo();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/car_input_ctrl.md
Name: car_input_ctrl

Overview:
- Upstream stage of the game-control block. Conditions raw board buttons for two cars.
- Per car it produces the 3-bit acceleration level and the 2-bit omega steering code that game control consumes once per frame.
- Raw buttons are synchronised and debounced. Acceleration ramps up and down in frame-tick steps, so the car's inputs change only on frame boundaries.

Parameters:
- DEBOUNCE_CYCLES, 250000, consecutive i_clk cycles a raw level must hold before the debounced state changes (5 ms at 50 MHz).
- ACC_MAX, 7, saturation value of the acceleration level.
- RAMP_FRAMES, 4, frame ticks of held throttle per +1 acceleration step.
- TURBO_FRAMES, 30, frame ticks turbo forces ACC_MAX (optional feature only).
- TURBO_COOLDOWN, 120, frame ticks after turbo before it can re-arm (optional feature only).

Ports:
- i_clk  in  1  system clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_frame_tick  in  1  one-cycle pulse, synchronous to i_clk, once per rendered frame.
- i_car1_btn_n  in  4  raw car1 buttons, active-low, asynchronous: [0] throttle, [1] brake, [2] left, [3] right.
- i_car2_btn_n  in  4  raw car2 buttons, same mapping.
- i_car1_turbo_n  in  1  raw car1 turbo button, active-low; ignored without the macro.
- i_car2_turbo_n  in  1  raw car2 turbo button, active-low; ignored without the macro.
- o_car1_acc  out  3  car1 acceleration level, 0..ACC_MAX.
- o_car2_acc  out  3  car2 acceleration level.
- o_car1_omega  out  2  car1 steering code.
- o_car2_omega  out  2  car2 steering code.
- o_car1_turbo_active  out  1  turbo currently forcing car1 acceleration.
- o_car2_turbo_active  out  1  turbo currently forcing car2 acceleration.

Behaviour:
- Clocking and reset: one clock, i_clk. Reset is asynchronous, active-low, on i_rst_n. Every register clears immediately on reset assertion, including mid-ramp or mid-turbo.
- Reset values:
  - o_car*_acc = 0.
  - o_car*_omega = 2'b01 (hold).
  - o_car*_turbo_active = 0.
  - Synchroniser flops = 1 (released); debounced state = released; all counters = 0.
- Synchronisation: each raw bit passes through a 2-flop synchroniser, then is inverted to active-high.
- Debounce:
  - Per bit, a counter runs while the synchronised level differs from the stable state.
  - When the counter reaches DEBOUNCE_CYCLES-1, the stable state flips and the counter clears.
  - Any cycle where the level matches the stable state clears the counter.
  - A glitch shorter than DEBOUNCE_CYCLES never reaches the stable state.
- Update timing: all outputs are registered and change only in the cycle after i_frame_tick. Each tick samples the current debounced state, even if a debounce transition is in progress.
- Per-car acceleration, evaluated on each tick in priority order:
  1. Brake held (brake wins over throttle): acc := 0, ramp_cnt := 0.
  2. Throttle held: if ramp_cnt == RAMP_FRAMES-1, then acc := min(acc+1, ACC_MAX) and ramp_cnt := 0; otherwise ramp_cnt := ramp_cnt+1.
  3. Neither held: acc := max(acc-1, 0), ramp_cnt := 0.
- Saturation: acc never wraps; it stays at ACC_MAX or at 0.
- Omega, updated on tick:
  - Left only → 2'b10 (+1).
  - Right only → 2'b00 (-1).
  - Neither or both → 2'b01 (hold).
- Cars are fully independent. Car1 and car2 logic share no state.
- Latency: from debounced edge to output is at most one frame period plus one cycle. From a raw edge it is 2 + DEBOUNCE_CYCLES cycles plus the wait for the next tick plus one cycle.

Optional Feature:
- Macro: CAR_INPUT_TURBO_EN.
- With the macro defined, per car, evaluated on tick:
  - A debounced turbo rising edge with cooldown == 0 loads turbo_cnt := TURBO_FRAMES and sets turbo_active.
  - While turbo_active: acc := ACC_MAX unconditionally, turbo_cnt decrements, brake is ignored, ramp_cnt := 0.
  - When turbo_cnt reaches 0: turbo_active clears, cooldown := TURBO_COOLDOWN, and the normal ramp resumes from ACC_MAX.
  - Cooldown decrements once per tick. Turbo presses during cooldown are ignored and not queued.
- Without the macro: turbo inputs are unconnected internally, o_car*_turbo_active is tied to 0, and no turbo counters are synthesised.

Decomposition:
- game_pkg adds:
  - ACC_WIDTH = 3.
  - OMEGA_POS = 2'b10, OMEGA_NEG = 2'b00, OMEGA_HOLD = 2'b01.
  - Button-index constants BTN_THROTTLE = 0, BTN_BRAKE = 1, BTN_LEFT = 2, BTN_RIGHT = 3.
- Sub-module button_debounce: synchroniser plus debounce counter for one bit, parameterised by DEBOUNCE_CYCLES. Instantiate 8 copies, or 10 with turbo.
- The per-car ramp/turbo logic is written once in car_input_ctrl and used for both cars, via a generate loop or duplicated always blocks.

Test Plan (DEBOUNCE_CYCLES=4, RAMP_FRAMES=2, TURBO_FRAMES=3, TURBO_COOLDOWN=2, tick every 20 cycles):
1. Reset then idle 100 cycles → acc = 0, omega = 01, turbo_active = 0 on both cars.
2. Car1 throttle held 400 cycles → acc reaches 1 on tick 2, 2 on tick 4, and saturates at 7 from tick 14. Throttle released → acc steps down by 1 per tick to 0. Car2 remains 0 throughout.
3. Car1 throttle pulse of 3 cycles → acc stays 0. Brake asserted with throttle at acc = 5 → acc = 0 in the cycle after the next tick.
4. Left only → omega 10. Right only → 00. Both → 01. Changes appear only in the cycle after a tick.
5. Assert i_rst_n low mid-ramp (acc = 4) and between ticks → acc = 0 and omega = 01 immediately, without waiting for a clock edge.
6. With CAR_INPUT_TURBO_EN at acc = 2, press turbo → acc = 7 and turbo_active = 1 for 3 ticks, brake ignored. A second press during the 2-tick cooldown is ignored. Without the macro, the same stimulus leaves acc = 2 and turbo_active = 0.
